// File: rtl/imem_arbiter_if.sv
// Bundles the fetch, loader and BRAM signals of imem_arbiter.
// The arbiter uses the slave modport; a requester/memory model uses master.
interface imem_arbiter_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            f_req;
  logic [XLEN-1:0] f_addr0;
  logic [XLEN-1:0] f_addr1;
  logic            f_flush;
  logic            f_gnt;
  logic            f_rvalid;
  logic [XLEN-1:0] f_pc0;
  logic [XLEN-1:0] f_pc1;
  logic [XLEN-1:0] f_rdata0;
  logic [XLEN-1:0] f_rdata1;

  logic            l_req;
  logic            l_we;
  logic [XLEN-1:0] l_addr;
  logic [XLEN-1:0] l_wdata;
  logic            l_gnt;
  logic            l_rvalid;
  logic [XLEN-1:0] l_rdata;

  logic            m_en;
  logic            m_we;
  logic [XLEN-1:0] m_addr0;
  logic [XLEN-1:0] m_addr1;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_rdata0;
  logic [XLEN-1:0] m_rdata1;

  modport slave (
    input  f_req, f_addr0, f_addr1, f_flush,
    output f_gnt, f_rvalid, f_pc0, f_pc1, f_rdata0, f_rdata1,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output m_en, m_we, m_addr0, m_addr1, m_wdata,
    input  m_rdata0, m_rdata1
  );

  modport master (
    output f_req, f_addr0, f_addr1, f_flush,
    input  f_gnt, f_rvalid, f_pc0, f_pc1, f_rdata0, f_rdata1,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_en, m_we, m_addr0, m_addr1, m_wdata,
    output m_rdata0, m_rdata1
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates the dual-port instruction BRAM between fetch and the loader/debug port.
// Optional performance counters are built when IMEM_ARB_PERF_EN is defined.
module imem_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              reset,
  imem_arbiter_if.slave     bus
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_fetch_gnt,
  output logic [31:0]       perf_load_gnt,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush_drop
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_LEN);

  localparam logic [0:0] FETCH_PRI  = 1'b0;
  localparam logic [0:0] LOAD_BURST = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            pend_f_q, pend_f_d;
  logic            pend_l_q, pend_l_d;
  logic [XLEN-1:0] pc0_q, pc0_d;
  logic [XLEN-1:0] pc1_q, pc1_d;

  logic f_live;
  logic f_gnt_c;
  logic l_gnt_c;

  assign f_live = bus.f_req & ~bus.f_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH_PRI;
      starve_q <= '0;
      burst_q  <= '0;
      pend_f_q <= 1'b0;
      pend_l_q <= 1'b0;
      pc0_q    <= '0;
      pc1_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      pend_f_q <= pend_f_d;
      pend_l_q <= pend_l_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
    end
  end

  // Grant selection, burst/starvation bookkeeping and response capture.
  always_comb begin
    f_gnt_c  = 1'b0;
    l_gnt_c  = 1'b0;
    state_d  = state_q;
    burst_d  = burst_q;
    starve_d = starve_q;

    if (!reset) begin
      if (state_q == LOAD_BURST) begin
        if (bus.l_req) l_gnt_c = 1'b1;
        else           f_gnt_c = f_live;
      end else if (bus.l_req && ((starve_q == STARVE_LIM) || !f_live)) begin
        l_gnt_c = 1'b1;
      end else begin
        f_gnt_c = f_live;
      end
    end

    if (state_q == LOAD_BURST) begin
      if (!bus.l_req || ((burst_q + BW'(1)) >= BURST_LIM)) begin
        state_d = FETCH_PRI;
        burst_d = '0;
      end else begin
        burst_d = burst_q + BW'(1);
      end
    end else if (l_gnt_c && (BURST_LEN > 1)) begin
      state_d = LOAD_BURST;
      burst_d = BW'(1);
    end

    if (!bus.l_req || l_gnt_c)      starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);

    // Single-stage response pipeline; only fetch reads carry PCs.
    pend_f_d = f_gnt_c;
    pend_l_d = l_gnt_c & ~bus.l_we;
    pc0_d    = f_gnt_c ? bus.f_addr0 : '0;
    pc1_d    = f_gnt_c ? bus.f_addr1 : '0;
  end

  assign bus.f_gnt    = f_gnt_c;
  assign bus.l_gnt    = l_gnt_c;
  assign bus.m_en     = f_gnt_c | l_gnt_c;
  assign bus.m_we     = l_gnt_c & bus.l_we;
  assign bus.m_addr0  = l_gnt_c ? bus.l_addr : (f_gnt_c ? bus.f_addr0 : '0);
  assign bus.m_addr1  = l_gnt_c ? bus.l_addr : (f_gnt_c ? bus.f_addr1 : '0);
  assign bus.m_wdata  = l_gnt_c ? bus.l_wdata : '0;

  assign bus.f_rvalid = pend_f_q;
  assign bus.f_pc0    = pc0_q;
  assign bus.f_pc1    = pc1_q;
  assign bus.f_rdata0 = pend_f_q ? bus.m_rdata0 : '0;
  assign bus.f_rdata1 = pend_f_q ? bus.m_rdata1 : '0;
  assign bus.l_rvalid = pend_l_q;
  assign bus.l_rdata  = pend_l_q ? bus.m_rdata0 : '0;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_fetch_q, perf_load_q, perf_stall_q, perf_drop_q;

  // A flush while a fetch response is presented means fetch discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_load_q  <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (f_gnt_c)                                   perf_fetch_q <= perf_fetch_q + 32'd1;
      if (l_gnt_c)                                   perf_load_q  <= perf_load_q + 32'd1;
      if (bus.f_req && !f_gnt_c && !bus.f_flush)     perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.f_flush && pend_f_q)                   perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign perf_fetch_gnt  = perf_fetch_q;
  assign perf_load_gnt   = perf_load_q;
  assign perf_stall      = perf_stall_q;
  assign perf_flush_drop = perf_drop_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a behavioural 1-cycle BRAM.
`timescale 1ns/1ps
module tb_imem_arbiter;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;
  int   cyc;

  imem_arbiter_if #(.XLEN(32)) bus ();

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_fetch_gnt, perf_load_gnt, perf_stall, perf_flush_drop;
  imem_arbiter #(.XLEN(32), .STARVE_MAX(4), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .perf_fetch_gnt(perf_fetch_gnt), .perf_load_gnt(perf_load_gnt),
    .perf_stall(perf_stall), .perf_flush_drop(perf_flush_drop));
`else
  imem_arbiter #(.XLEN(32), .STARVE_MAX(4), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct { int due; logic [31:0] pc0, pc1, d0, d1; } fexp_t;
  typedef struct { int due; logic [31:0] d; } lexp_t;
  fexp_t fq[$];
  lexp_t lq[$];

  logic [31:0] mem     [0:63];
  logic [31:0] exp_mem [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: write on port 0, registered reads on both ports.
  always @(posedge clk) begin
    if (bus.m_en === 1'b1) begin
      if (bus.m_we === 1'b1) mem[bus.m_addr0[7:2]] <= bus.m_wdata;
      bus.m_rdata0 <= mem[bus.m_addr0[7:2]];
      bus.m_rdata1 <= mem[bus.m_addr1[7:2]];
    end
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return exp_mem[a[7:2]];
  endfunction

  // Response scoreboard: each expected entry is due exactly one cycle after its grant.
  always @(negedge clk) begin
    fexp_t fe;
    lexp_t le;
    if (bus.f_rvalid === 1'b1) begin
      nvec++;
      if (fq.size() != 0 && fq[0].due == cyc) begin
        fe = fq.pop_front();
        if ({bus.f_pc0, bus.f_pc1, bus.f_rdata0, bus.f_rdata1} !== {fe.pc0, fe.pc1, fe.d0, fe.d1}) begin
          nerr++;
          $display("FAIL f_resp cyc=%0d got pc=%h/%h d=%h/%h exp pc=%h/%h d=%h/%h", cyc,
                   bus.f_pc0, bus.f_pc1, bus.f_rdata0, bus.f_rdata1, fe.pc0, fe.pc1, fe.d0, fe.d1);
        end
      end else begin
        nerr++;
        $display("FAIL f_resp_unexpected cyc=%0d got f_rvalid=1 exp 0", cyc);
      end
    end else if (fq.size() != 0 && fq[0].due == cyc) begin
      nvec++; nerr++;
      fe = fq.pop_front();
      $display("FAIL f_resp_missing cyc=%0d got f_rvalid=%b exp 1", cyc, bus.f_rvalid);
    end

    if (bus.l_rvalid === 1'b1) begin
      nvec++;
      if (lq.size() != 0 && lq[0].due == cyc) begin
        le = lq.pop_front();
        if (bus.l_rdata !== le.d) begin
          nerr++;
          $display("FAIL l_resp cyc=%0d got %h exp %h", cyc, bus.l_rdata, le.d);
        end
      end else begin
        nerr++;
        $display("FAIL l_resp_unexpected cyc=%0d got l_rvalid=1 exp 0", cyc);
      end
    end else if (lq.size() != 0 && lq[0].due == cyc) begin
      nvec++; nerr++;
      le = lq.pop_front();
      $display("FAIL l_resp_missing cyc=%0d got l_rvalid=%b exp 1", cyc, bus.l_rvalid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.f_req = 1'b0; bus.f_flush = 1'b0;
    bus.l_req = 1'b0; bus.l_we = 1'b0;
  endtask

  task automatic push_f(input logic [31:0] a0, input logic [31:0] a1);
    fq.push_back('{due: cyc + 1, pc0: a0, pc1: a1, d0: word(a0), d1: word(a1)});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.f_req = 1'b1; bus.f_addr0 = 32'h40; bus.f_addr1 = 32'h44;
    bus.l_req = 1'b1; bus.l_addr = 32'h20;
    tick(); tick(); #2;
    nvec++;
    if ({bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we, bus.f_rvalid, bus.l_rvalid} !== 6'b0 ||
        bus.m_addr0 !== 32'h0 || bus.f_pc0 !== 32'h0 || bus.f_rdata0 !== 32'h0 || bus.l_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_state got gnt=%b%b en=%b rv=%b%b addr=%h pc0=%h exp all 0",
               bus.f_gnt, bus.l_gnt, bus.m_en, bus.f_rvalid, bus.l_rvalid, bus.m_addr0, bus.f_pc0);
    end
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_fetch_stream();
    logic [31:0] a0, a1;
    for (int i = 0; i < 3; i++) begin
      a0 = 32'(8 * i); a1 = a0 + 32'd4;
      bus.f_req = 1'b1; bus.f_addr0 = a0; bus.f_addr1 = a1;
      #2;
      nvec++;
      if ({bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we} !== 4'b1010 ||
          bus.m_addr0 !== a0 || bus.m_addr1 !== a1) begin
        nerr++;
        $display("FAIL fetch_stream[%0d] got gnt=%b%b en=%b we=%b a=%h/%h exp 1010 a=%h/%h", i,
                 bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we, bus.m_addr0, bus.m_addr1, a0, a1);
      end
      push_f(a0, a1);
      tick();
    end
    idle(); tick(); tick();
  endtask

  task automatic test_starve_burst();
    logic [12:0] lpat;
    logic        el;
    logic [31:0] a0;
    lpat = 13'b1_0000_1111_0000;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h20;
    for (int i = 0; i < 13; i++) begin
      a0 = 32'h40 + 32'(8 * i);
      bus.f_req = 1'b1; bus.f_addr0 = a0; bus.f_addr1 = a0 + 32'd4;
      #2;
      el = lpat[i];
      nvec++;
      if (bus.l_gnt !== el || bus.f_gnt !== ~el || bus.m_addr0 !== (el ? 32'h20 : a0)) begin
        nerr++;
        $display("FAIL starve_burst[%0d] got f_gnt=%b l_gnt=%b addr0=%h exp f_gnt=%b l_gnt=%b addr0=%h",
                 i, bus.f_gnt, bus.l_gnt, bus.m_addr0, ~el, el, el ? 32'h20 : a0);
      end
      if (el) lq.push_back('{due: cyc + 1, d: word(32'h20)});
      else    push_f(a0, a0 + 32'd4);
      tick();
    end
    idle(); tick(); tick();
  endtask

  task automatic test_write_read();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h08; bus.l_wdata = 32'hDEADBEEF;
    #2;
    nvec++;
    if ({bus.l_gnt, bus.m_we} !== 2'b11 || bus.m_addr0 !== 32'h08 || bus.m_wdata !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL write_grant got l_gnt=%b m_we=%b addr=%h wdata=%h exp 1 1 00000008 deadbeef",
               bus.l_gnt, bus.m_we, bus.m_addr0, bus.m_wdata);
    end
    exp_mem[2] = 32'hDEADBEEF;
    tick();
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    bus.f_req = 1'b1; bus.f_addr0 = 32'h08; bus.f_addr1 = 32'h0C;
    #2;
    nvec++;
    if (bus.f_gnt !== 1'b1 || bus.l_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL write_then_fetch got f_gnt=%b l_rvalid=%b exp 1 0", bus.f_gnt, bus.l_rvalid);
    end
    push_f(32'h08, 32'h0C);
    tick();
    idle(); tick(); tick();
  endtask

  task automatic test_flush();
    bus.f_req = 1'b1; bus.f_addr0 = 32'h10; bus.f_addr1 = 32'h14;
    #2;
    nvec++;
    if (bus.f_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL flush_pre_gnt got %b exp 1", bus.f_gnt);
    end
    push_f(32'h10, 32'h14);
    tick();
    bus.f_flush = 1'b1;
    #2;
    nvec++;
    if ({bus.f_gnt, bus.m_en, bus.f_rvalid} !== 3'b001) begin
      nerr++;
      $display("FAIL flush_cycle got f_gnt=%b m_en=%b f_rvalid=%b exp 0 0 1",
               bus.f_gnt, bus.m_en, bus.f_rvalid);
    end
    tick();
    idle();
    #2;
    nvec++;
    if (bus.f_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_after got f_rvalid=%b exp 0", bus.f_rvalid);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h30;
    #2;
    nvec++;
    if (bus.l_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL rmb_gnt0 got l_gnt=%b exp 1", bus.l_gnt);
    end
    lq.push_back('{due: cyc + 1, d: word(32'h30)});
    tick();
    bus.l_addr = 32'h34;
    #2;
    nvec++;
    if (bus.l_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL rmb_gnt1 got l_gnt=%b exp 1", bus.l_gnt);
    end
    lq.push_back('{due: cyc + 1, d: word(32'h34)});
    tick();
    reset = 1'b1;
    bus.f_req = 1'b1; bus.f_addr0 = 32'h18; bus.f_addr1 = 32'h1C;
    #2;
    nvec++;
    if ({bus.f_gnt, bus.l_gnt, bus.m_en} !== 3'b000) begin
      nerr++;
      $display("FAIL rmb_reset_gnt got f_gnt=%b l_gnt=%b m_en=%b exp 000", bus.f_gnt, bus.l_gnt, bus.m_en);
    end
    tick();
    #2;
    nvec++;
    if ({bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we, bus.f_rvalid, bus.l_rvalid} !== 6'b0 ||
        bus.l_rdata !== 32'h0 || bus.f_pc0 !== 32'h0 || bus.m_addr0 !== 32'h0) begin
      nerr++;
      $display("FAIL rmb_outputs got gnt=%b%b en=%b rv=%b%b l_rdata=%h exp all 0",
               bus.f_gnt, bus.l_gnt, bus.m_en, bus.f_rvalid, bus.l_rvalid, bus.l_rdata);
    end
    tick();
    reset = 1'b0;
    #2;
    nvec++;
    if ({bus.f_gnt, bus.l_gnt} !== 2'b10) begin
      nerr++;
      $display("FAIL rmb_first_gnt got f_gnt=%b l_gnt=%b exp 1 0", bus.f_gnt, bus.l_gnt);
    end
    push_f(32'h18, 32'h1C);
    tick();
    idle(); tick(); tick();
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hC0DE0000 + 32'(i);
      exp_mem[i] = 32'hC0DE0000 + 32'(i);
    end
    bus.m_rdata0 = '0; bus.m_rdata1 = '0;
    bus.f_addr0 = '0; bus.f_addr1 = '0; bus.l_addr = '0; bus.l_wdata = '0;
    idle();
    reset = 1'b1;

    test_reset();
    test_fetch_stream();
    test_starve_burst();
    test_write_read();
    test_flush();
    test_reset_mid_burst();

    tick();
    nvec++;
    if (fq.size() + lq.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", fq.size() + lq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the dual-port, synchronous instruction BRAM (1-cycle read latency) between the fetch stage and a program-loader/debug port.
- Grants one requester per cycle, bounds loader starvation and batches loader accesses into short bursts.
- Tracks the in-flight read and routes the response, tagged with its PCs, back to the owner.
- Drops fetch responses that a fetch redirect/flush has made stale.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced a grant; must be >=1.
- BURST_LEN, 4, maximum consecutive loader grants per burst; must be >=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch read request for a pair of addresses
- f_addr0  in  XLEN  fetch slot-0 PC
- f_addr1  in  XLEN  fetch slot-1 PC
- f_flush  in  1  redirect; kills the fetch request this cycle and any fetch response in flight
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch response valid
- f_pc0  out  XLEN  PC echoed for slot 0
- f_pc1  out  XLEN  PC echoed for slot 1
- f_rdata0  out  XLEN  slot-0 instruction
- f_rdata1  out  XLEN  slot-1 instruction
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  XLEN  loader byte address
- l_wdata  in  XLEN  loader write data
- l_gnt  out  1  loader request accepted
- l_rvalid  out  1  loader read data valid
- l_rdata  out  XLEN  loader read data
- m_en  out  1  BRAM enable
- m_we  out  1  BRAM write enable (port 0 only)
- m_addr0  out  XLEN  BRAM port-0 address
- m_addr1  out  XLEN  BRAM port-1 address
- m_wdata  out  XLEN  BRAM write data
- m_rdata0  in  XLEN  BRAM port-0 read data, valid 1 cycle after m_en
- m_rdata1  in  XLEN  BRAM port-1 read data, valid 1 cycle after m_en

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = FETCH_PRI.
  - Starvation counter = 0, burst counter = 0.
  - Response pipeline empty.
- Grant logic is combinational from the current state and requests.
- m_* mirror the granted requester in the same cycle:
  - fetch grant: m_addr0=f_addr0, m_addr1=f_addr1, m_we=0.
  - loader grant: m_addr0=l_addr, m_addr1=l_addr, m_we=l_we, m_wdata=l_wdata.
- m_en = f_gnt | l_gnt. At most one grant per cycle.
- f_gnt = 0 whenever f_flush=1.
- FSM state FETCH_PRI:
  - Fetch wins if f_req & !f_flush, unless starve_cnt==STARVE_MAX and l_req, in which case the loader wins.
  - Loader wins when fetch is not requesting (or is flushed).
  - Any loader grant moves to LOAD_BURST with burst_cnt=1.
- FSM state LOAD_BURST:
  - Loader has priority while l_req.
  - Each loader grant increments burst_cnt.
  - Return to FETCH_PRI after the grant that makes burst_cnt==BURST_LEN, or on any cycle with l_req=0. burst_cnt clears on exit.
  - Fetch is granted in LOAD_BURST only on a cycle with l_req=0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle l_req=1 and l_gnt=0.
  - Clears on l_gnt or l_req=0.
- Response pipeline: one registered stage.
  - At a grant, record owner, PCs and is_read.
  - Next cycle, present m_rdata* to the owner:
    - f_rvalid=1 with f_pc0/1 = recorded PCs, f_rdata0/1 = m_rdata0/1.
    - or l_rvalid=1, l_rdata=m_rdata0, for loader reads only. Loader writes produce no response.
- Flush:
  - f_flush=1 while a fetch response is in flight clears the pending entry, so f_rvalid=0 the next cycle.
  - A flush on the same cycle the response is presented does not retract it; fetch discards it itself.
- Throughput: fetch alone sustains 1 grant/cycle, with f_rvalid following each grant by exactly 1 cycle.
- Simultaneous f_req, l_req with starve_cnt<STARVE_MAX in FETCH_PRI: fetch granted.
- Reset asserted mid-burst or with a response in flight: returns to reset values next edge; no stale response is ever presented.

Optional Feature:
- Macro: IMEM_ARB_PERF_EN.
- When defined, adds outputs perf_fetch_gnt, perf_load_gnt, perf_stall and perf_flush_drop, each 32 bits. They count, respectively:
  - fetch grants
  - loader grants
  - cycles with f_req & !f_gnt & !f_flush
  - in-flight fetch responses killed by flush
- All counters clear on reset and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Fetch-only stream: f_req=1 with addrs 0x00/0x04, 0x08/0x0C, 0x10/0x14 on consecutive cycles -> f_gnt=1 every cycle; f_rvalid 1 cycle later each time, with matching PCs and the BRAM data at those words.
- Starvation: f_req and l_req held high, l_we=0, l_addr=0x20, STARVE_MAX=4 -> 4 fetch grants, then l_gnt on cycle 5; l_rvalid=1 next cycle with l_rdata=mem[0x20>>2].
- Burst: loader granted, then l_req held 6 cycles with f_req high, BURST_LEN=4 -> exactly 4 consecutive l_gnt, then f_gnt; starve_cnt restarts from 0.
- Write then read: loader writes 0xDEADBEEF to 0x08 (no l_rvalid), then fetch reads 0x08/0x0C -> f_rdata0=0xDEADBEEF.
- Flush: fetch granted at 0x10/0x14, f_flush=1 the next cycle -> f_rvalid=0 on the following cycle, and f_gnt=0 in the flush cycle even with f_req=1.
- Reset mid-burst: assert reset during LOAD_BURST with a read in flight -> all outputs 0 the next cycle; first post-reset grant goes to fetch when both requesters are active.
